// File: rtl/skew_pkg.sv
// skew_pkg: shared types and width helpers for the skew feeder slice.
//   bank_state_t  : life cycle of one ping-pong bank
//   beat_cnt_w()  : width of the per-bank beat counter / length register
//   step_cnt_w()  : width of the drain step counter
//   row_idx_w()   : width of a bank row address (never zero)
package skew_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    function automatic int unsigned beat_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned step_cnt_w(input int unsigned depth, input int unsigned rows);
        return $clog2(depth + rows);
    endfunction

    function automatic int unsigned row_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// skew_feeder_if: valid/ready write channel carrying one K-slice per beat.
//   wr_valid : beat offered by the loader
//   wr_ready : feeder can accept the beat
//   wr_last  : beat closes the current tile
//   wr_data  : ROWS signed elements, element i belongs to lane i
// Modports: master = loader side, slave = feeder side.
interface skew_feeder_if #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned DATA_WIDTH = 8
);

    logic                         wr_valid;
    logic                         wr_ready;
    logic                         wr_last;
    logic signed [DATA_WIDTH-1:0] wr_data [ROWS];

    modport master (output wr_valid, output wr_last, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_last, input wr_data, output wr_ready);

endinterface

// File: rtl/skew_bank.sv
// skew_bank: one ping-pong bank of the skew feeder.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous abort, bank returns to EMPTY
//   wr_en         : accepted beat targeting this bank
//   wr_last       : accepted beat closes the tile
//   wr_data       : one K-slice, stored at row = beat index
//   start         : drain step issued from this bank
//   drain_done    : final drain step issued, bank released
//   rd_row        : per-lane row address
//   rd_data       : lane i element from row rd_row[i]
//   state, len    : bank state and tile length (valid once FULL)
//   at_last_slot  : the next accepted beat fills the final row
module skew_bank
    import skew_pkg::*;
#(
    parameter  int unsigned ROWS       = 8,
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned CW         = beat_cnt_w(DEPTH),
    localparam int unsigned RW         = row_idx_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic                         wr_last,
    input  logic signed [DATA_WIDTH-1:0] wr_data [ROWS],
    input  logic                         start,
    input  logic                         drain_done,
    input  logic [RW-1:0]                rd_row  [ROWS],
    output logic signed [DATA_WIDTH-1:0] rd_data [ROWS],
    output bank_state_t                  state,
    output logic [CW-1:0]                len,
    output logic                         at_last_slot
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH][ROWS];
    logic [CW-1:0]                cnt;

    assign at_last_slot = (cnt == CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt[RW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ROWS; i++) begin
            rd_data[i] = mem[rd_row[i]][i];
        end
    end

    // Writer and reader never target the same bank in one cycle: the writer
    // only sees EMPTY/FILLING banks, the reader only FULL/DRAINING ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= '0;
            len   <= '0;
        end else if (clear) begin
            state <= EMPTY;
            cnt   <= '0;
            len   <= '0;
        end else if (wr_en) begin
            if (wr_last || at_last_slot) begin
                state <= FULL;
                len   <= cnt + 1'b1;
                cnt   <= '0;
            end else begin
                state <= FILLING;
                cnt   <= cnt + 1'b1;
            end
        end else if (drain_done) begin
            state <= EMPTY;
        end else if (start) begin
            state <= DRAINING;
        end
    end

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: double-buffered skew buffer feeding operand rows into a
// systolic array. Lane i of drain step s carries row s-i of the active bank,
// producing the diagonal wavefront.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous abort of all tiles (beats write and advance)
//   wr          : write channel (slave modport), one K-slice per beat
//   advance     : global array step enable
//   data_out    : registered lane outputs, zero where the lane is idle
//   lane_valid  : per-lane element valid
//   tile_start  : pulse, step 0 of a tile was issued
//   tile_done   : pulse, final step of a tile was issued
module skew_feeder
    import skew_pkg::*;
#(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    skew_feeder_if.slave                 wr,
    input  logic                         advance,
    output logic signed [DATA_WIDTH-1:0] data_out [ROWS],
    output logic [ROWS-1:0]              lane_valid,
    output logic                         tile_start,
    output logic                         tile_done
);

    localparam int unsigned CW = beat_cnt_w(DEPTH);
    localparam int unsigned SW = step_cnt_w(DEPTH, ROWS);
    localparam int unsigned RW = row_idx_w(DEPTH);

    logic                         wsel;
    logic                         rsel;
    logic [SW-1:0]                step;

    bank_state_t                  st0, st1, wr_state, rd_state;
    logic [CW-1:0]                len0, len1, rd_len;
    logic                         last0, last1, wr_at_last;
    logic signed [DATA_WIDTH-1:0] rd0 [ROWS];
    logic signed [DATA_WIDTH-1:0] rd1 [ROWS];
    logic signed [DATA_WIDTH-1:0] rd_cur [ROWS];
    logic [RW-1:0]                rd_row [ROWS];
    logic [ROWS-1:0]              lane_hit;

    logic accept, closing, issue, last_step;

    assign wr_state   = wsel ? st1 : st0;
    assign wr_at_last = wsel ? last1 : last0;
    assign rd_state   = rsel ? st1 : st0;
    assign rd_len     = rsel ? len1 : len0;

    assign wr.wr_ready = (wr_state == EMPTY) || (wr_state == FILLING);
    assign accept      = wr.wr_valid && wr.wr_ready && !flush;
    assign closing     = accept && (wr.wr_last || wr_at_last);
    assign issue       = advance && !flush && ((rd_state == FULL) || (rd_state == DRAINING));

    always_comb begin
        int unsigned step_u;
        int unsigned len_u;
        step_u    = 32'(step);
        len_u     = 32'(rd_len);
        last_step = (step_u + 2 == len_u + ROWS);
        for (int unsigned i = 0; i < ROWS; i++) begin
            lane_hit[i] = 1'b0;
            rd_row[i]   = '0;
            rd_cur[i]   = rsel ? rd1[i] : rd0[i];
            if (step_u >= i && (step_u - i) < len_u) begin
                lane_hit[i] = 1'b1;
                rd_row[i]   = RW'(step_u - i);
            end
        end
    end

    skew_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .wr_en        (accept && !wsel),
        .wr_last      (wr.wr_last),
        .wr_data      (wr.wr_data),
        .start        (issue && !rsel),
        .drain_done   (issue && !rsel && last_step),
        .rd_row       (rd_row),
        .rd_data      (rd0),
        .state        (st0),
        .len          (len0),
        .at_last_slot (last0)
    );

    skew_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .wr_en        (accept && wsel),
        .wr_last      (wr.wr_last),
        .wr_data      (wr.wr_data),
        .start        (issue && rsel),
        .drain_done   (issue && rsel && last_step),
        .rd_row       (rd_row),
        .rd_data      (rd1),
        .state        (st1),
        .len          (len1),
        .at_last_slot (last1)
    );

    // An advancing cycle with nothing to issue is a bubble: the array still
    // steps, so the lanes present zeros rather than repeating the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            step       <= '0;
            data_out   <= '{default: '0};
            lane_valid <= '0;
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
        end else if (flush) begin
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            step       <= '0;
            data_out   <= '{default: '0};
            lane_valid <= '0;
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
        end else begin
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
            if (closing) begin
                wsel <= ~wsel;
            end
            if (issue) begin
                for (int unsigned i = 0; i < ROWS; i++) begin
                    data_out[i] <= lane_hit[i] ? rd_cur[i] : '0;
                end
                lane_valid <= lane_hit;
                tile_start <= (step == '0);
                tile_done  <= last_step;
                if (last_step) begin
                    step <= '0;
                    rsel <= ~rsel;
                end else begin
                    step <= step + 1'b1;
                end
            end else if (advance) begin
                data_out   <= '{default: '0};
                lane_valid <= '0;
            end
        end
    end

endmodule
